// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the arbitrated restoring divider.
//   DIV_WIDTH : default operand/result width
//   state_e   : controller state encoding (IDLE, RUN, DONE)
package div_pkg;

    localparam int DIV_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_core.sv
// div_core: iterative restoring divider datapath, one quotient bit per step.
//   clk, resetn        : clock, synchronous active-low reset
//   load               : capture dividend/divisor and clear the step counter
//   step               : perform one restoring step (MSB first)
//   dividend, divisor  : operands, sampled on load
//   quo_next, rem_next : quotient/remainder as they will be after this step
//   last               : current step is the final one of the operation
//   dz                 : captured divisor is zero
module div_core import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo_next,
    output logic [WIDTH-1:0] rem_next,
    output logic             last,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH + 1);

    // quo_q starts as the dividend and is shifted left each step; the freed
    // LSB collects the quotient bit, so after WIDTH steps it holds the quotient.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;

    // The stored remainder is always below the divisor, so WIDTH bits hold it;
    // the shifted value and trial difference need the extra bit.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        diff     = shifted - {1'b0, dvs_q};
        fits     = ~diff[WIDTH];
        rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

    generate
        if (WIDTH == 1) begin : g_q1
            assign quo_next = fits;
        end else begin : g_qn
            assign quo_next = {quo_q[WIDTH-2:0], fits};
        end
    endgenerate

    assign last = (cnt_q == CW'(WIDTH - 1));
    assign dz   = (dvs_q == '0);

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = '0;
        end else if (step) begin
            rem_d = rem_next;
            quo_d = quo_next;
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: two-requester round-robin front end for a shared divider.
//   clk, resetn           : clock, synchronous active-low reset
//   req[1:0]              : divide request per requester (held until gnt)
//   dividend0/divisor0    : requester 0 operands
//   dividend1/divisor1    : requester 1 operands
//   gnt[1:0]              : one-cycle pulse, operands of that requester captured
//   done[1:0]             : one-cycle pulse, result for that requester ready
//   quotient, remainder   : result of the last completed operation
//   dz                    : last completed operation had a zero divisor
//   busy                  : controller not in IDLE
module div_arbiter import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] dividend0,
    input  logic [WIDTH-1:0] divisor0,
    input  logic [WIDTH-1:0] dividend1,
    input  logic [WIDTH-1:0] divisor1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             win_q, win_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dz_q, dz_d;

    logic             pick;
    logic             load;
    logic             step;
    logic [WIDTH-1:0] op_dividend;
    logic [WIDTH-1:0] op_divisor;
    logic [WIDTH-1:0] core_quo;
    logic [WIDTH-1:0] core_rem;
    logic             core_last;
    logic             core_dz;

    // A lone requester always wins; on contention the pointer decides.
    assign pick        = (req == 2'b11) ? ptr_q : req[1];
    assign op_dividend = pick ? dividend1 : dividend0;
    assign op_divisor  = pick ? divisor1  : divisor0;

    div_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .resetn   (resetn),
        .load     (load),
        .step     (step),
        .dividend (op_dividend),
        .divisor  (op_divisor),
        .quo_next (core_quo),
        .rem_next (core_rem),
        .last     (core_last),
        .dz       (core_dz)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        gnt_d       = '0;
        done_d      = '0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;
        load        = 1'b0;
        step        = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    load        = 1'b1;
                    win_d       = pick;
                    gnt_d[pick] = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                // Results are taken from the final step directly so they are
                // visible in the same cycle as the done pulse.
                if (core_last) begin
                    state_d       = DONE;
                    done_d[win_q] = 1'b1;
                    quotient_d    = core_quo;
                    remainder_d   = core_rem;
                    dz_d          = core_dz;
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = ~win_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            win_q       <= 1'b0;
            gnt_q       <= '0;
            done_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dz        = dz_q;
    assign busy      = (state_q != IDLE);

endmodule
